mem_stage: RTL and testbench

// Memory-access pipeline stage between execute and writeback. Latches the execute->memory bus and waits for the

---
 rtl/mem_stage_pkg.sv | 71 +++++++
 rtl/mem_load_align.sv | 37 +++
 rtl/mem_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_stage.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus layouts, load op indices and FSM states
// shared by the memory stage and its load aligner.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ms_state_e;

  localparam int LD_W  = 0;
  localparam int LD_H  = 1;
  localparam int LD_HU = 2;
  localparam int LD_B  = 3;
  localparam int LD_BU = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  ld_op;
    logic [2:0]  st_op;
    logic [4:0]  dest;
    logic        gr_we;
    logic        res_from_cnt;
    logic        res_from_mem;
    logic        res_from_csr;
    logic [1:0]  addr;
    logic [31:0] alu_result;
    logic [31:0] timer;
    logic        excp;
    logic [5:0]  excp_num;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        req_sent;
  } es_to_ms_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        gr_we;
    logic [31:0] final_result;
    logic        excp;
    logic [5:0]  excp_num;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        res_from_csr;
    logic        ertn;
  } ms_to_ws_t;

  typedef struct packed {
    logic        data_pending;
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  dest;
    logic        gr_we;
    logic        valid;
  } ms_fwd_t;

  localparam int ES_BUS_W = $bits(es_to_ms_t);
  localparam int WS_BUS_W = $bits(ms_to_ws_t);
  localparam int FWD_W    = $bits(ms_fwd_t);

  function automatic logic needs_resp(es_to_ms_t b);
    return b.req_sent & ((|b.ld_op) | (|b.st_op));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed lane of a load word
// and sign- or zero-extends it to 32 bits.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [4:0]  ld_op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] value_o
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  always_comb begin
    half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (addr_i)
      2'd0: byte_v = rdata_i[7:0];
      2'd1: byte_v = rdata_i[15:8];
      2'd2: byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
  end

  always_comb begin
    value_o = rdata_i;
    unique case (1'b1)
      ld_op_i[LD_W]:  value_o = rdata_i;
      ld_op_i[LD_H]:  value_o = {{16{half[15]}}, half};
      ld_op_i[LD_HU]: value_o = {16'd0, half};
      ld_op_i[LD_B]:  value_o = {{24{byte_v[7]}}, byte_v};
      ld_op_i[LD_BU]: value_o = {24'd0, byte_v};
      default:        value_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; waits for data_ok, aligns
// load data and absorbs orphan responses left by a flush.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ES_TO_MS_BUS_WD = ES_BUS_W,
  parameter int MS_TO_WS_BUS_WD = WS_BUS_W,
  parameter int MS_FORWARD_WD   = FWD_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_FORWARD_WD-1:0]   ms_forward,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       excp_flush,
  input  logic                       ertn_flush
);

  es_to_ms_t   es_in;
  es_to_ms_t   bus_q, bus_d;
  ms_state_e   state_q, state_d;
  logic        ms_valid_q, ms_valid_d;
  logic [1:0]  cancel_q, cancel_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_q, buf_d;

  logic        flush;
  logic        need_resp;
  logic        resp_ok;
  logic        ms_ready_go;
  logic        accept;
  logic        accept_resp;
  logic        buf_capture;
  logic [2:0]  cnt_sum;
  logic [31:0] rdata_sel;
  logic [31:0] load_val;
  logic [31:0] result;
  logic        gr_we_out;
  ms_to_ws_t   ws_out;
  ms_fwd_t     fwd_out;

  assign es_in       = es_to_ms_bus;
  assign flush       = excp_flush | ertn_flush;
  assign need_resp   = ms_valid_q & needs_resp(bus_q);
  // Responses only belong to us once every orphan is drained.
  assign resp_ok     = data_sram_data_ok & (cancel_q == 2'd0)
                     & (state_q == S_WAIT);
  assign ms_ready_go = ~need_resp | buf_valid_q | resp_ok;
  assign ms_allowin  = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign accept      = es_to_ms_valid & ms_allowin;
  assign accept_resp = accept & needs_resp(es_in);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (ms_allowin) begin
      state_d = accept_resp ? S_WAIT : S_IDLE;
    end else begin
      case (state_q)
        S_WAIT:  if (resp_ok) state_d = S_HOLD;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    buf_capture = (state_q == S_WAIT) & resp_ok
                & ~ws_allowin & ~flush;
  end

  always_comb begin
    cnt_sum = {1'b0, cancel_q};
    if (flush)
      cnt_sum = cnt_sum + {2'b0, state_q == S_WAIT}
              + {2'b0, accept_resp};
    if (data_sram_data_ok && cnt_sum != 3'd0)
      cnt_sum = cnt_sum - 3'd1;
    cancel_d = (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];
  end

  always_comb begin
    ms_valid_d  = ms_valid_q;
    bus_d       = bus_q;
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    if (flush) begin
      ms_valid_d  = 1'b0;
      buf_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d  = es_to_ms_valid;
      buf_valid_d = 1'b0;
      if (es_to_ms_valid) bus_d = es_in;
    end else if (buf_capture) begin
      buf_valid_d = 1'b1;
      buf_d       = data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      bus_q       <= '0;
      cancel_q    <= 2'd0;
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      bus_q       <= bus_d;
      cancel_q    <= cancel_d;
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
    end
  end

  assign rdata_sel = buf_valid_q ? buf_q : data_sram_rdata;

  mem_load_align u_align (
    .ld_op_i (bus_q.ld_op),
    .addr_i  (bus_q.addr),
    .rdata_i (rdata_sel),
    .value_o (load_val)
  );

  always_comb begin
    if (bus_q.res_from_mem)      result = load_val;
    else if (bus_q.res_from_cnt) result = bus_q.timer;
    else                         result = bus_q.alu_result;
  end

  assign gr_we_out = bus_q.gr_we & ~bus_q.excp & ~(|bus_q.st_op);

  always_comb begin
    ws_out.pc           = bus_q.pc;
    ws_out.dest         = bus_q.dest;
    ws_out.gr_we        = gr_we_out;
    ws_out.final_result = result;
    ws_out.excp         = bus_q.excp;
    ws_out.excp_num     = bus_q.excp_num;
    ws_out.csr_we       = bus_q.csr_we;
    ws_out.csr_num      = bus_q.csr_num;
    ws_out.csr_wmask    = bus_q.csr_wmask;
    ws_out.csr_wvalue   = bus_q.csr_wvalue;
    ws_out.res_from_csr = bus_q.res_from_csr;
    ws_out.ertn         = bus_q.ertn;
  end

  always_comb begin
    fwd_out.data_pending = ms_valid_q & bus_q.res_from_mem & ~ms_ready_go;
    fwd_out.pc           = bus_q.pc;
    fwd_out.result       = result;
    fwd_out.dest         = bus_q.dest;
    fwd_out.gr_we        = gr_we_out;
    fwd_out.valid        = ms_valid_q;
  end

  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
  assign ms_to_ws_bus   = ws_out;
  assign ms_forward     = fwd_out;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus random traffic checked
// against a transaction-level model of the memory stage.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                ws_allowin;
  logic                ms_allowin;
  logic                es_to_ms_valid;
  logic [ES_BUS_W-1:0] es_to_ms_bus;
  logic                ms_to_ws_valid;
  logic [WS_BUS_W-1:0] ms_to_ws_bus;
  logic [FWD_W-1:0]    ms_forward;
  logic                data_sram_data_ok;
  logic [31:0]         data_sram_rdata;
  logic                excp_flush;
  logic                ertn_flush;

  es_to_ms_t cur;
  ms_to_ws_t ws_o;
  assign es_to_ms_bus = cur;
  assign ws_o = ms_to_ws_bus;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_forward        (ms_forward),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .excp_flush        (excp_flush),
    .ertn_flush        (ertn_flush)
  );

  int errs = 0;
  int checks = 0;

  task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: one instruction slot, whether its response arrived,
  // and how many responses still belong to flushed work.
  es_to_ms_t   m_inst;
  bit          m_valid, m_got;
  logic [31:0] m_data;
  int          m_orph, mem_pend;
  bit          attr, ready, allowin, es_taken;

  function automatic bit needs(es_to_ms_t i);
    return i.req_sent && (i.ld_op != 0 || i.st_op != 0);
  endfunction

  function automatic logic [31:0] ref_load(es_to_ms_t i, logic [31:0] w);
    logic [15:0] h;
    logic [7:0]  b;
    h = 16'(w >> (16 * int'(i.addr[1])));
    b = 8'(w >> (8 * int'(i.addr)));
    if (i.ld_op[LD_H])  return 32'($signed(h));
    if (i.ld_op[LD_HU]) return 32'(h);
    if (i.ld_op[LD_B])  return 32'($signed(b));
    if (i.ld_op[LD_BU]) return 32'(b);
    return w;
  endfunction

  task automatic eval_model();
    bit mn;
    mn = m_valid && needs(m_inst);
    attr = data_sram_data_ok && m_orph == 0 && mn && !m_got;
    ready = !mn || m_got || attr;
    allowin = !m_valid || (ready && ws_allowin);
  endtask

  function automatic logic [31:0] m_result();
    logic [31:0] w;
    w = m_got ? m_data : data_sram_rdata;
    if (m_inst.res_from_mem) return ref_load(m_inst, w);
    if (m_inst.res_from_cnt) return m_inst.timer;
    return m_inst.alu_result;
  endfunction

  task automatic sample();
    ms_to_ws_t e;
    bit        we;
    @(negedge clk);
    eval_model();
    we = m_inst.gr_we && !m_inst.excp && m_inst.st_op == 0;
    check("ws_valid", 256'(ms_to_ws_valid), 256'(m_valid && ready));
    check("allowin", 256'(ms_allowin), 256'(allowin));
    check("fwd_valid", 256'(ms_forward[0]), 256'(m_valid));
    check("fwd_pend", 256'(ms_forward[71]),
          256'(m_valid && m_inst.res_from_mem && !ready));
    if (m_valid) begin
      check("fwd_data", 256'(ms_forward[70:1]),
            256'({m_inst.pc, m_result(), m_inst.dest, we}));
    end
    if (m_valid && ready) begin
      e.pc           = m_inst.pc;
      e.dest         = m_inst.dest;
      e.gr_we        = we;
      e.final_result = m_result();
      e.excp         = m_inst.excp;
      e.excp_num     = m_inst.excp_num;
      e.csr_we       = m_inst.csr_we;
      e.csr_num      = m_inst.csr_num;
      e.csr_wmask    = m_inst.csr_wmask;
      e.csr_wvalue   = m_inst.csr_wvalue;
      e.res_from_csr = m_inst.res_from_csr;
      e.ertn         = m_inst.ertn;
      check("ws_bus", 256'(ms_to_ws_bus), 256'(e));
    end
  endtask

  task automatic advance();
    bit acc_new;
    int outst;
    @(posedge clk);
    eval_model();
    es_taken = es_to_ms_valid && allowin;
    acc_new = es_taken && needs(cur) && !reset;
    if (reset) begin
      m_valid = 0; m_got = 0; m_orph = 0;
    end else if (excp_flush || ertn_flush) begin
      outst = m_orph + ((m_valid && needs(m_inst) && !m_got) ? 1 : 0)
            + (acc_new ? 1 : 0);
      if (data_sram_data_ok && outst > 0) outst--;
      m_orph = outst > 3 ? 3 : outst;
      m_valid = 0; m_got = 0;
    end else begin
      if (data_sram_data_ok && m_orph > 0) m_orph--;
      if (allowin) begin
        m_valid = es_to_ms_valid;
        if (es_to_ms_valid) m_inst = cur;
        m_got = 0;
      end else if (attr) begin
        m_got = 1;
        m_data = data_sram_rdata;
      end
    end
    if (data_sram_data_ok && mem_pend > 0) mem_pend--;
    if (acc_new) mem_pend++;
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  function automatic es_to_ms_t mk_alu(logic [31:0] pc, logic [31:0] r);
    es_to_ms_t i;
    i = '0;
    i.pc = pc; i.dest = 5'd3; i.gr_we = 1'b1;
    i.alu_result = r; i.timer = 32'h7777_0000;
    return i;
  endfunction

  function automatic es_to_ms_t mk_ld(int op, logic [1:0] a, logic [31:0] pc);
    es_to_ms_t i;
    i = '0;
    i.pc = pc; i.dest = 5'd7; i.gr_we = 1'b1;
    i.ld_op[op] = 1'b1; i.res_from_mem = 1'b1;
    i.addr = a; i.alu_result = {28'h1000_000, 2'b00, a};
    i.req_sent = 1'b1;
    return i;
  endfunction

  function automatic es_to_ms_t rand_inst();
    es_to_ms_t i;
    int k;
    i = '0;
    i.pc = $urandom & 32'hFFFF_FFFC;
    i.dest = 5'($urandom);
    i.alu_result = $urandom;
    i.timer = $urandom;
    i.excp_num = 6'($urandom);
    i.csr_we = 1'($urandom);
    i.csr_num = 14'($urandom);
    i.csr_wmask = $urandom;
    i.csr_wvalue = $urandom;
    i.res_from_csr = ($urandom_range(7) == 0);
    i.ertn = ($urandom_range(15) == 0);
    i.gr_we = 1'b1;
    k = $urandom_range(5);
    if ((k == 2 || k == 3) && mem_pend >= 2) k = 0;
    case (k)
      0: i.excp = ($urandom_range(7) == 0);
      1: i.res_from_cnt = 1'b1;
      2, 4: begin
        i.ld_op[$urandom_range(4)] = 1'b1;
        i.res_from_mem = 1'b1;
        i.addr = 2'($urandom);
        i.req_sent = (k == 2);
        i.excp = (k == 4);
      end
      default: begin
        i.st_op[$urandom_range(2)] = 1'b1;
        i.gr_we = 1'($urandom);
        i.addr = 2'($urandom);
        i.req_sent = (k == 3);
        i.excp = (k == 5);
      end
    endcase
    return i;
  endfunction

  task automatic idle_inputs();
    es_to_ms_valid = 0; data_sram_data_ok = 0;
    excp_flush = 0; ertn_flush = 0; ws_allowin = 1;
  endtask

  initial begin
    bit f;
    reset = 1; cur = '0; data_sram_rdata = 32'h0;
    m_inst = '0; m_valid = 0; m_got = 0; m_data = 0;
    m_orph = 0; mem_pend = 0; es_taken = 0;
    idle_inputs();
    @(posedge clk); #1;
    sample();
    check("rst_ws_valid", 256'(ms_to_ws_valid), 256'(0));
    check("rst_fwd_valid", 256'(ms_forward[0]), 256'(0));
    advance();
    reset = 0;

    // ALU instruction straight through
    cur = mk_alu(32'h1c00_0000, 32'h1234_5678); es_to_ms_valid = 1;
    step();
    es_to_ms_valid = 0;
    sample();
    check("alu_valid", 256'(ms_to_ws_valid), 256'(1));
    check("alu_res", 256'(ws_o.final_result), 256'(32'h1234_5678));
    check("alu_pend", 256'(ms_forward[71]), 256'(0));
    advance();

    // ld.b / ld.bu at byte lane 3
    for (int p = 0; p < 2; p++) begin
      cur = mk_ld(p == 0 ? LD_B : LD_BU, 2'd3, 32'h1c00_0010);
      es_to_ms_valid = 1;
      step();
      es_to_ms_valid = 0;
      sample();
      check("ldb_pend", 256'(ms_forward[71]), 256'(1));
      advance();
      step();
      data_sram_data_ok = 1; data_sram_rdata = 32'h80FF_1234;
      sample();
      check("ldb_valid", 256'(ms_to_ws_valid), 256'(1));
      check("ldb_res", 256'(ws_o.final_result),
            256'(p == 0 ? 32'hFFFF_FF80 : 32'h0000_0080));
      advance();
      data_sram_data_ok = 0;
    end

    // ld.h upper half, writeback stalled -> buffered
    cur = mk_ld(LD_H, 2'd2, 32'h1c00_0020); es_to_ms_valid = 1;
    step();
    es_to_ms_valid = 0; ws_allowin = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'h8001_0000;
    step();
    data_sram_data_ok = 0; data_sram_rdata = 32'h0;
    sample();
    check("ldh_hold", 256'(ws_o.final_result), 256'(32'hFFFF_8001));
    advance();
    ws_allowin = 1;
    sample();
    check("ldh_valid", 256'(ms_to_ws_valid), 256'(1));
    check("ldh_res", 256'(ws_o.final_result), 256'(32'hFFFF_8001));
    advance();
    sample();
    check("ldh_once", 256'(ms_to_ws_valid), 256'(0));
    advance();

    // flush in WAIT leaves one orphan response
    cur = mk_ld(LD_W, 2'd0, 32'h1c00_0030); es_to_ms_valid = 1;
    step();
    es_to_ms_valid = 0; excp_flush = 1;
    step();
    excp_flush = 0;
    cur = mk_ld(LD_W, 2'd0, 32'h1c00_0034); es_to_ms_valid = 1;
    step();
    es_to_ms_valid = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'h0000_DEAD;
    sample();
    check("orph_drop", 256'(ms_to_ws_valid), 256'(0));
    advance();
    data_sram_rdata = 32'h0000_1234;
    sample();
    check("orph_next", 256'(ms_to_ws_valid), 256'(1));
    check("orph_res", 256'(ws_o.final_result), 256'(32'h0000_1234));
    advance();
    data_sram_data_ok = 0;

    // data_ok and flush together: consumed, no orphan
    cur = mk_ld(LD_W, 2'd0, 32'h1c00_0040); es_to_ms_valid = 1;
    step();
    es_to_ms_valid = 0; data_sram_data_ok = 1; excp_flush = 1;
    step();
    data_sram_data_ok = 0; excp_flush = 0;
    sample();
    check("dokfl_valid", 256'(ms_to_ws_valid), 256'(0));
    advance();
    cur = mk_ld(LD_W, 2'd0, 32'h1c00_0044); es_to_ms_valid = 1;
    step();
    es_to_ms_valid = 0; data_sram_data_ok = 1;
    data_sram_rdata = 32'hCAFE_0001;
    sample();
    check("dokfl_next", 256'(ms_to_ws_valid), 256'(1));
    check("dokfl_res", 256'(ws_o.final_result), 256'(32'hCAFE_0001));
    advance();
    data_sram_data_ok = 0;

    // excepting store passes without waiting
    cur = '0; cur.pc = 32'h1c00_0050; cur.st_op = 3'b100;
    cur.gr_we = 1; cur.excp = 1; cur.excp_num = 6'h09;
    cur.alu_result = 32'h0000_0101;
    es_to_ms_valid = 1;
    step();
    es_to_ms_valid = 0;
    sample();
    check("st_valid", 256'(ms_to_ws_valid), 256'(1));
    check("st_grwe", 256'(ws_o.gr_we), 256'(0));
    check("st_excp", 256'(ws_o.excp_num), 256'(6'h09));
    advance();

    // reset mid-WAIT, then a stray data_ok
    cur = mk_ld(LD_W, 2'd0, 32'h1c00_0060); es_to_ms_valid = 1;
    step();
    es_to_ms_valid = 0; reset = 1;
    step();
    reset = 0; data_sram_data_ok = 1;
    sample();
    check("stray_valid", 256'(ms_to_ws_valid), 256'(0));
    advance();
    data_sram_data_ok = 0;
    step();

    // random traffic
    es_taken = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!es_to_ms_valid || es_taken) begin
        es_to_ms_valid = ($urandom_range(3) != 0);
        cur = rand_inst();
      end
      ws_allowin = ($urandom_range(3) != 0);
      data_sram_data_ok = (mem_pend > 0) && ($urandom_range(2) == 0);
      data_sram_rdata = $urandom;
      eval_model();
      f = ($urandom_range(15) == 0) && (!es_to_ms_valid || allowin);
      excp_flush = f && ($urandom_range(1) == 1);
      ertn_flush = f && !excp_flush;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
